// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x oversampled serial frame decoder (5-8 data bits, optional parity, 1/2 stop) into a FWFT receive FIFO.
// Latency: a frame is written in its final stop-sample cycle; rx_valid rises on the following cycle.
// Backpressure: rx_ready pops the head; a frame arriving while full is dropped with an overrun pulse; rts_n pauses the peer.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_THRESHOLD = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       uart_rx,
    output logic       rts_n,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_C   = CW'(RTS_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    // Line synchronizer and receiver state
    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_perr;
    logic          r_ferr;
    logic [1:0]    r_cfg_bits;
    logic          r_cfg_par_en;
    logic          r_cfg_par_odd;
    logic          r_cfg_stop2;

    // Decoded strobes
    logic          w_mid_tick;
    logic          w_bit_tick;
    logic          w_last_bit;
    logic          w_par_exp;
    logic          w_start_det;
    logic          w_start_ok;
    logic          w_data_smp;
    logic          w_par_smp;
    logic          w_stop1_smp;
    logic          w_push;
    rx_entry_t     w_push_entry;

    // Receive FIFO
    rx_entry_t     r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rts_n;
    logic          r_overrun;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    rx_entry_t     w_head;

    // Start bit is checked mid-bit (8th tick); every later bit one full bit-time after the previous sample
    assign w_mid_tick = baud_tick && (r_cnt == 4'd7);
    assign w_bit_tick = baud_tick && (r_cnt == 4'd15);
    assign w_last_bit = (r_bit_idx == ({1'b0, r_cfg_bits} + 3'd4));
    // Unused upper data bits stay 0, so reducing over all 8 bits gives the parity of the received bits
    assign w_par_exp  = (^r_shift) ^ r_cfg_par_odd;

    // Frame error of the pushed entry folds in the stop sample being taken this cycle
    assign w_push_entry = '{frame_err: r_ferr | ~r_rx_s, parity_err: r_perr, data: r_shift};

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (baud_tick && !r_rx_s) w_state_nxt = S_START;
            S_START:  if (w_mid_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_tick && w_last_bit) w_state_nxt = r_cfg_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_bit_tick) w_state_nxt = S_STOP1;
            S_STOP1:  if (w_bit_tick) w_state_nxt = r_cfg_stop2 ? S_STOP2 : S_IDLE;
            S_STOP2:  if (w_bit_tick) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: per-state sample strobes and the FIFO push
    always_comb begin
        w_start_det = 1'b0;
        w_start_ok  = 1'b0;
        w_data_smp  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop1_smp = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:   w_start_det = baud_tick && !r_rx_s;
            S_START:  w_start_ok  = w_mid_tick && !r_rx_s;
            S_DATA:   w_data_smp  = w_bit_tick;
            S_PARITY: w_par_smp   = w_bit_tick;
            S_STOP1: begin
                w_stop1_smp = w_bit_tick;
                w_push      = w_bit_tick && !r_cfg_stop2;
            end
            S_STOP2:  w_push      = w_bit_tick;
            default:  ;
        endcase
    end

    // Oversample counter: re-zeroed at start detection and at the confirmed start-bit centre
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (w_start_det || w_start_ok) begin
            r_cnt <= 4'd0;
        end else if (baud_tick) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Frame datapath: config is frozen at start detection so mid-frame cfg changes cannot disturb it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cfg_bits    <= 2'd0;
            r_cfg_par_en  <= 1'b0;
            r_cfg_par_odd <= 1'b0;
            r_cfg_stop2   <= 1'b0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'd0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_cfg_bits    <= cfg_data_bits;
                r_cfg_par_en  <= cfg_parity_en;
                r_cfg_par_odd <= cfg_parity_odd;
                r_cfg_stop2   <= cfg_stop2;
                r_bit_idx     <= 3'd0;
                r_shift       <= 8'd0;
                r_perr        <= 1'b0;
                r_ferr        <= 1'b0;
            end
            if (w_data_smp) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (w_par_smp) begin
                r_perr <= (r_rx_s != w_par_exp);
            end
            if (w_stop1_smp && !r_rx_s) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = !w_empty && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage; contents are don't-care until written, outputs are masked while empty
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Registered flow control and overrun pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rts_n   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_rts_n   <= (r_count >= RTS_C);
            r_overrun <= w_push && w_full && !w_pop;
        end
    end

    assign rts_n         = r_rts_n;
    assign overrun_err   = r_overrun;
    assign rx_valid      = !w_empty;
    assign rx_data       = w_empty ? 8'h00 : w_head.data;
    assign rx_parity_err = !w_empty && w_head.parity_err;
    assign rx_frame_err  = !w_empty && w_head.frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH    = 8;
    localparam int RTS_THRESHOLD = 6;
    localparam int TD            = 4;   // clocks per baud_tick

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       baud_tick = 1'b0;
    logic       uart_rx   = 1'b1;
    logic       rts_n;
    logic [1:0] cfg_data_bits  = 2'b11;
    logic       cfg_parity_en  = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2      = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun_err;

    int checks   = 0;
    int failures = 0;
    int ov_count = 0;
    logic [9:0] sb [$];   // expected {frame_err, parity_err, data}

    uart_rx_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .RTS_THRESHOLD (RTS_THRESHOLD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .baud_tick      (baud_tick),
        .uart_rx        (uart_rx),
        .rts_n          (rts_n),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    // Free-running 16x baud enable, one clock wide every TD clocks
    initial begin
        int tdiv;
        tdiv = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (tdiv == 0);
            tdiv = (tdiv + 1) % TD;
        end
    end

    always @(negedge clk) begin
        if (overrun_err === 1'b1) ov_count++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Hold the line at v for nticks baud ticks; returns just after a posedge
    task automatic drive_bit(input logic v, input int nticks);
        uart_rx = v;
        repeat (nticks * TD) @(posedge clk);
        #1;
    endtask

    // Send one frame and record its expected FIFO entry (or nothing if the bench model says FIFO is full)
    task automatic send_frame(input logic [7:0] d, input logic [1:0] bits, input logic par_en,
                              input logic par_odd, input logic stop2, input logic flip_par,
                              input logic stop1_v, input logic stop2_v);
        int         nb;
        logic [7:0] dm;
        logic       par;
        logic       ferr;
        logic       perr;
        logic       last_bad;
        nb   = int'(bits) + 5;
        dm   = d & 8'((1 << nb) - 1);
        par  = (^dm) ^ par_odd ^ flip_par;
        ferr = !stop1_v || (stop2 && !stop2_v);
        perr = par_en && flip_par;
        if (sb.size() < FIFO_DEPTH) sb.push_back({ferr, perr, dm});
        cfg_data_bits  = bits;
        cfg_parity_en  = par_en;
        cfg_parity_odd = par_odd;
        cfg_stop2      = stop2;
        drive_bit(1'b0, 4);
        // scramble config once the start bit has been seen; the frame must keep its latched settings
        cfg_data_bits  = 2'($urandom);
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
        drive_bit(1'b0, 12);
        for (int i = 0; i < nb; i++) drive_bit(dm[i], 16);
        if (par_en) drive_bit(par, 16);
        last_bad = stop2 ? !stop2_v : !stop1_v;
        if (stop2) begin
            drive_bit(stop1_v, 16);
            drive_bit(stop2_v, stop2_v ? 16 : 10);
        end else begin
            drive_bit(stop1_v, stop1_v ? 16 : 10);
        end
        if (last_bad) drive_bit(1'b1, 16);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        uart_rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if ({rx_frame_err, rx_parity_err} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {rx_frame_err, rx_parity_err}); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun_err); end
        checks++; if (rts_n !== 1'b1) begin failures++; $display("FAIL reset_rts got=%b exp=1", rts_n); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (rts_n !== 1'b1) begin failures++; $display("FAIL release_rts_hold got=%b exp=1", rts_n); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rts_n !== 1'b0) begin failures++; $display("FAIL release_rts got=%b exp=0", rts_n); end
        @(posedge clk); #1;
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL 8n1_valid_held got=%b exp=1", rx_valid); end
        exp = sb.pop_front();
        checks++; if (rx_data !== exp[7:0]) begin failures++; $display("FAIL 8n1_data got=%h exp=%h", rx_data, exp[7:0]); end
        checks++; if ({rx_frame_err, rx_parity_err} !== exp[9:8]) begin failures++; $display("FAIL 8n1_errs got=%b exp=%b", {rx_frame_err, rx_parity_err}, exp[9:8]); end
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL 8n1_pop got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        logic [9:0] exp;
        int n;
        send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);  // 7E1, wrong parity
        send_frame(8'h15, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);  // 5O1, correct parity
        rx_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({rx_frame_err, rx_parity_err, rx_data} !== exp) begin
                    failures++; $display("FAIL parity_entry got=%h exp=%h", {rx_frame_err, rx_parity_err, rx_data}, exp);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL parity_drain_timeout got=%0d exp=0 left", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_stop2();
        logic [9:0] exp;
        int n;
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);  // 8N2, bad second stop
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // follow-up proves return to idle
        rx_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({rx_frame_err, rx_parity_err, rx_data} !== exp) begin
                    failures++; $display("FAIL stop2_entry got=%h exp=%h", {rx_frame_err, rx_parity_err, rx_data}, exp);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL stop2_drain_timeout got=%0d exp=0 left", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL stop2_extra_entry got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_glitch();
        logic [9:0] exp;
        int n;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_push got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
        send_frame(8'h2B, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // 6N1
        rx_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({rx_frame_err, rx_parity_err, rx_data} !== exp) begin
                    failures++; $display("FAIL glitch_next_entry got=%h exp=%h", {rx_frame_err, rx_parity_err, rx_data}, exp);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL glitch_drain_timeout got=%0d exp=0 left", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [9:0] exp;
        logic exp_rts;
        int   exp_ov;
        int   ov0;
        int   n;
        for (int i = 1; i <= 9; i++) begin
            exp_ov = (sb.size() == FIFO_DEPTH) ? 1 : 0;
            ov0 = ov_count;
            send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            exp_rts = (sb.size() >= RTS_THRESHOLD);
            @(negedge clk);
            checks++; if (rts_n !== exp_rts) begin failures++; $display("FAIL ovr_rts frame=%0d got=%b exp=%b", i, rts_n, exp_rts); end
            checks++; if ((ov_count - ov0) != exp_ov) begin failures++; $display("FAIL ovr_pulses frame=%0d got=%0d exp=%0d", i, ov_count - ov0, exp_ov); end
            @(posedge clk); #1;
        end
        rx_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({rx_frame_err, rx_parity_err, rx_data} !== exp) begin
                    failures++; $display("FAIL ovr_entry got=%h exp=%h", {rx_frame_err, rx_parity_err, rx_data}, exp);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovr_drain_timeout got=%0d exp=0 left", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_dropped_frame_present got=%b exp=0", rx_valid); end
        checks++; if (rts_n !== 1'b0) begin failures++; $display("FAIL ovr_rts_after_drain got=%b exp=0", rts_n); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        int n;
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        // 0x55: start, bits 0..2 = 1,0,1, then reset in the middle of bit 3
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        uart_rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (rts_n !== 1'b1) begin failures++; $display("FAIL rstmid_rts_during got=%b exp=1", rts_n); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rts_n !== 1'b0) begin failures++; $display("FAIL rstmid_rts_after got=%b exp=0", rts_n); end
        @(posedge clk); #1;
        drive_bit(1'b1, 48);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_partial_push got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
        send_frame(8'h66, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        rx_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({rx_frame_err, rx_parity_err, rx_data} !== exp) begin
                    failures++; $display("FAIL rstmid_entry got=%h exp=%h", {rx_frame_err, rx_parity_err, rx_data}, exp);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rstmid_drain_timeout got=%0d exp=0 left", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_extra_entry got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RTS_THRESHOLD, default 6, FIFO occupancy at which rts_n deasserts (1..FIFO_DEPTH).
REQ-003 SHALL have ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-cycle enable at 16x baud rate.
- uart_rx  input  1  asynchronous serial line, idle high.
- rts_n  output  1  flow control to peer; 0 = may send.
- cfg_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- cfg_parity_en  input  1  parity bit present.
- cfg_parity_odd  input  1  1=odd, 0=even parity.
- cfg_stop2  input  1  1=two stop bits.
- rx_data  output  8  FIFO head data, LSB-aligned, unused MSBs 0.
- rx_parity_err  output  1  parity error flag of head entry.
- rx_frame_err  output  1  framing error flag of head entry.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts head.
- overrun_err  output  1  one-cycle pulse, frame dropped.

Function
REQ-004 SHALL pass uart_rx through a 2-flop synchronizer; only the synchronized value (rx_s) is used.
REQ-005 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-006 SHALL use a 4-bit tick counter that advances only on baud_tick and wraps 15->0.
REQ-007 IDLE: on baud_tick with rx_s=0, SHALL clear the counter, latch all cfg_* inputs, and go to START.
REQ-008 START: at the 8th tick (counter=7), rx_s=1 SHALL return to IDLE (glitch, no push); rx_s=0 SHALL clear the counter and go to DATA.
REQ-009 Every later bit SHALL be sampled when the counter reaches 15 (16 ticks after the previous sample).
REQ-010 DATA SHALL shift in bits LSB first, for the latched bit count, then go to PARITY if parity is enabled, else STOP1.
REQ-011 PARITY SHALL compare the sample with the parity of the data bits (even or odd as latched); a mismatch sets the frame's parity error.
REQ-012 STOP1: sample=0 SHALL set the frame error; with cfg_stop2 latched, go to STOP2, else push and go to IDLE.
REQ-013 STOP2: sample=0 SHALL set the frame error; then push and go to IDLE.
REQ-014 A push SHALL write {frame_err, parity_err, data} to the FIFO in the final stop-sample cycle; rx_valid rises the following cycle.
REQ-015 The FIFO SHALL be first-word-fall-through; rx_data and the error flags always show the head entry.
REQ-016 A pop SHALL occur when rx_valid && rx_ready.
REQ-017 Push while full without a pop in the same cycle SHALL drop the frame, leave the FIFO unchanged, and pulse overrun_err for one cycle.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-019 Pop while empty SHALL be ignored.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a counter of width clog2(FIFO_DEPTH)+1.
REQ-021 rts_n SHALL be registered: 1 when occupancy >= RTS_THRESHOLD, else 0, updated the cycle after an occupancy change.
REQ-022 cfg_* changes mid-frame SHALL NOT affect the frame in progress.
REQ-023 A frame in progress SHALL complete regardless of rts_n.

Reset
REQ-024 With reset_n=0 at a clk edge: FSM=IDLE, counter=0, synchronizer flops=1, FIFO empty, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, overrun_err=0, rts_n=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, no push occurs until a new start bit is detected.
REQ-026 The cycle after reset release, rts_n SHALL go to 0 (occupancy 0 < threshold).

Verification
REQ-027 8N1, send 0xA5 -> one entry: rx_data=0xA5, parity_err=0, frame_err=0; rx_valid held until rx_ready=1.
REQ-028 7E1, send 0x41 with parity bit 1 (correct parity is 0) -> rx_data=0x41, rx_parity_err=1.
REQ-029 8N2, send 0x3C with second stop bit 0 -> rx_data=0x3C, rx_frame_err=1; FSM back to IDLE.
REQ-030 Line low for 4 ticks, then high -> no push; FSM back to IDLE.
REQ-031 rx_ready=0, send 9 frames 0x01..0x09 -> rts_n=1 after 6th push; 9th frame dropped with one overrun_err pulse; pops return 0x01..0x08 in order.
REQ-032 Assert reset_n=0 during data bit 3 of 0x55, then send 0x66 -> only 0x66 received; rts_n 1 during reset, 0 after.
